seq_mult32: RTL

// - Multi-cycle unsigned 32x32 -> 64-bit shift-and-add multiplier; the repeated-addition counterpart of the subtract-based datapath.
// - Sits beside the combinational add32/sub32 units in the ALU; the ALU control FSM issues a start pulse and waits for done.
// - Built on one add32 instance, reused on every iteration; no combinational multiplier array.

---
 rtl/seq_mult32_pkg.sv | 10 +
 rtl/seq_mult32_add32.sv | 10 +
 rtl/seq_mult32.sv | 64 ++++++
 3 files changed

// File: rtl/seq_mult32_pkg.sv
// seq_mult32_pkg: constants and state encodings shared by the multiplier and the ALU control FSM.
package seq_mult32_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_mult32_add32.sv
// add32: 32-bit unsigned ripple adder with carry in/out.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        cout,
    output logic [31:0] sum
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

// File: rtl/seq_mult32.sv
// seq_mult32: multi-cycle unsigned shift-and-add multiplier reusing a single add32.
module seq_mult32
    import seq_mult32_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    state_t           state;
    logic [WIDTH-1:0] mcand, hi, lo, addSum;
    logic [CNT_W-1:0] cnt;
    logic             addCout;
    logic [WIDTH:0]   sum33;

    add32 uAdd (.a(hi), .b(mcand), .cin(1'b0), .cout(addCout), .sum(addSum));

    // Carry-out becomes the top bit so it lands in bit 63 after the shift.
    always_comb sum33 = lo[0] ? {addCout, addSum} : {1'b0, hi};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        mcand <= multiplicand;
                        hi    <= '0;
                        lo    <= multiplier;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    busy  <= 1'b1;
                    {hi, lo} <= {sum33, lo[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CNT_W'(WIDTH-1)) ? S_DONE : S_RUN;
                end
                S_DONE: begin
                    busy    <= 1'b1;
                    done    <= 1'b1;
                    product <= {hi, lo};
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
